// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: write-back requester handshakes and register file write port
interface wb_port_arbiter_if #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     alu_valid, alu_ready, mem_valid, mem_ready, WEN, alu_promoted;
  logic [ADDRESS_WIDTH-1:0] alu_rd, mem_rd, WA3;
  logic [WORD_WIDTH-1:0]    alu_data, mem_data, WD3;
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, WA3, WD3, WEN, alu_promoted
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, WA3, WD3, WEN, alu_promoted
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register file write port between ALU and load write-back
module wb_port_arbiter #(
  parameter int WORD_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_port_arbiter_if.slave     bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  logic                     run_q, live, promoted, alu_gnt, mem_gnt;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     wen_q, wen_d;
  logic [ADDRESS_WIDTH-1:0] wa3_q, wa3_d;
  logic [WORD_WIDTH-1:0]    wd3_q, wd3_d;
  // run_q delays the first grant to the cycle after reset is sampled released
  always_comb begin
    live     = rst_n && run_q;
    promoted = rst_n && (cnt_q == LIMIT);
    alu_gnt  = live && bus.alu_valid && (!bus.mem_valid || promoted);
    mem_gnt  = live && bus.mem_valid && !alu_gnt;
    cnt_d    = (!bus.alu_valid || alu_gnt) ? '0 : (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
    wen_d    = alu_gnt ? |bus.alu_rd : mem_gnt ? |bus.mem_rd : 1'b0;
    wa3_d    = alu_gnt ? bus.alu_rd : mem_gnt ? bus.mem_rd : wa3_q;
    wd3_d    = alu_gnt ? bus.alu_data : mem_gnt ? bus.mem_data : wd3_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      wen_q <= 1'b0;
      wa3_q <= '0;
      wd3_q <= '0;
    end else begin
      run_q <= 1'b1;
      cnt_q <= run_q ? cnt_d : '0;
      wen_q <= wen_d;
      wa3_q <= wa3_d;
      wd3_q <= wd3_d;
    end
  end
  assign bus.alu_ready    = alu_gnt;
  assign bus.mem_ready    = mem_gnt;
  assign bus.alu_promoted = promoted;
  assign bus.WEN          = wen_q;
  assign bus.WA3          = wa3_q;
  assign bus.WD3          = wd3_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vector table plus a starvation-bound sequence
module tb_wb_port_arbiter;
  localparam int W = 32;
  localparam int A = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  wb_port_arbiter_if #(.WORD_WIDTH(W), .ADDRESS_WIDTH(A)) bus ();
  wb_port_arbiter #(.WORD_WIDTH(W), .ADDRESS_WIDTH(A), .STARVE_LIMIT(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  typedef struct {
    logic         r, av, mv, ar, mr, pr, wen;
    logic [A-1:0] ard, mrd, wa3;
    logic [W-1:0] ad, md, wd3;
  } vec_t;
  vec_t vq[$];
  int passed = 0;
  int total  = 0;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic add(input logic r, input logic av, input logic [A-1:0] ard, input logic [W-1:0] ad,
                     input logic mv, input logic [A-1:0] mrd, input logic [W-1:0] md,
                     input logic ar, input logic mr, input logic pr,
                     input logic wen, input logic [A-1:0] wa3, input logic [W-1:0] wd3);
    vec_t v;
    v.r = r; v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md;
    v.ar = ar; v.mr = mr; v.pr = pr; v.wen = wen; v.wa3 = wa3; v.wd3 = wd3;
    vq.push_back(v);
  endtask
  task automatic drive(input logic r, input logic av, input logic [A-1:0] ard, input logic [W-1:0] ad,
                       input logic mv, input logic [A-1:0] mrd, input logic [W-1:0] md);
    rst_n = r;
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = md;
  endtask
  initial begin
    int k;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    // r  av ard ad            mv mrd md      ar mr pr wen wa3 wd3
    add(0, 1, 4, 32'h22,       1, 3, 32'h11,   0, 0, 0, 0, 0, 32'h0);
    add(0, 1, 4, 32'h22,       1, 3, 32'h11,   0, 0, 0, 0, 0, 32'h0);
    add(0, 1, 4, 32'h22,       1, 3, 32'h11,   0, 0, 0, 0, 0, 32'h0);
    add(1, 1, 4, 32'h22,       1, 3, 32'h11,   0, 0, 0, 0, 0, 32'h0);
    add(1, 1, 4, 32'h22,       1, 3, 32'h11,   0, 1, 0, 0, 0, 32'h0);
    add(1, 1, 4, 32'h22,       0, 0, 32'h0,    1, 0, 0, 1, 3, 32'h11);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 1, 4, 32'h22);
    add(1, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,    1, 0, 0, 0, 4, 32'h22);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 1, 5, 32'hDEADBEEF);
    add(1, 1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,    1, 0, 0, 0, 5, 32'hDEADBEEF);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 0, 0, 32'hFFFFFFFF);
    add(1, 1, 9, 32'h90,       1, 8, 32'h80,   0, 1, 0, 0, 0, 32'hFFFFFFFF);
    add(1, 1, 9, 32'h90,       1, 8, 32'h80,   0, 1, 0, 1, 8, 32'h80);
    add(1, 1, 9, 32'h90,       1, 8, 32'h80,   0, 1, 0, 1, 8, 32'h80);
    add(1, 1, 9, 32'h90,       1, 8, 32'h80,   1, 0, 1, 1, 8, 32'h80);
    add(1, 0, 0, 32'h0,        1, 8, 32'h80,   0, 1, 0, 1, 9, 32'h90);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 1, 8, 32'h80);
    add(1, 1, 7, 32'hB,        1, 7, 32'hA,    0, 1, 0, 0, 8, 32'h80);
    add(1, 1, 7, 32'hB,        0, 0, 32'h0,    1, 0, 0, 1, 7, 32'hA);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 1, 7, 32'hB);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 0, 7, 32'hB);
    add(1, 1, 2, 32'h2,        1, 1, 32'h1,    0, 1, 0, 0, 7, 32'hB);
    add(1, 1, 2, 32'h2,        1, 1, 32'h1,    0, 1, 0, 1, 1, 32'h1);
    add(1, 0, 0, 32'h0,        1, 1, 32'h1,    0, 1, 0, 1, 1, 32'h1);
    add(1, 1, 2, 32'h2,        1, 1, 32'h1,    0, 1, 0, 1, 1, 32'h1);
    add(1, 1, 2, 32'h2,        1, 1, 32'h1,    0, 1, 0, 1, 1, 32'h1);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 1, 1, 32'h1);
    add(1, 1, 6, 32'h66,       0, 0, 32'h0,    1, 0, 0, 0, 1, 32'h1);
    add(0, 1, 6, 32'h66,       0, 0, 32'h0,    0, 0, 0, 1, 6, 32'h66);
    add(1, 1, 6, 32'h66,       0, 0, 32'h0,    0, 0, 0, 0, 0, 32'h0);
    add(1, 1, 6, 32'h66,       0, 0, 32'h0,    1, 0, 0, 0, 0, 32'h0);
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,    0, 0, 0, 1, 6, 32'h66);
    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].r, vq[i].av, vq[i].ard, vq[i].ad, vq[i].mv, vq[i].mrd, vq[i].md);
      #1;
      chk($sformatf("v%0d alu_ready", i), W'(bus.alu_ready), W'(vq[i].ar));
      chk($sformatf("v%0d mem_ready", i), W'(bus.mem_ready), W'(vq[i].mr));
      chk($sformatf("v%0d alu_promoted", i), W'(bus.alu_promoted), W'(vq[i].pr));
      chk($sformatf("v%0d WEN", i), W'(bus.WEN), W'(vq[i].wen));
      chk($sformatf("v%0d WA3", i), W'(bus.WA3), W'(vq[i].wa3));
      chk($sformatf("v%0d WD3", i), bus.WD3, vq[i].wd3);
    end
    // mem held high: ALU must win within STARVE_LIMIT+1 cycles
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1, 1, 11, 32'hBB, 1, 10, 32'hAA);
      #1;
      if (bus.alu_ready) break;
    end
    chk("starve_wait_cycles", W'(k), 32'd3);
    chk("starve_promoted", W'(bus.alu_promoted), 32'd1);
    chk("starve_mem_blocked", W'(bus.mem_ready), 32'd0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0);
    #1;
    chk("starve_WEN", W'(bus.WEN), 32'd1);
    chk("starve_WA3", W'(bus.WA3), 32'd11);
    chk("starve_WD3", bus.WD3, 32'hBB);
    chk("starve_cleared", W'(bus.alu_promoted), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
